alu_8: RTL and testbench



---
 rtl/alu_8_pkg.sv | 23 ++
 rtl/alu_8_if.sv | 13 +
 rtl/alu_8_addsub.sv | 16 +
 rtl/alu_8.sv | 90 +++++++++
 tb/tb_alu_8.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/alu_8_pkg.sv
// Shared types for the alu_8 execute stage: opcode encoding and datapath width.
package alu_8_pkg;
  localparam int DW = 8;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_NAND = 4'h6,
    OP_NOR  = 4'h7,
    OP_XNOR = 4'h8,
    OP_NOT  = 4'h9,
    OP_SHL  = 4'hA,
    OP_SHR  = 4'hB,
    OP_ROL  = 4'hC,
    OP_ROR  = 4'hD,
    OP_INC  = 4'hE,
    OP_CMP  = 4'hF
  } op_e;
endpackage

// File: rtl/alu_8_if.sv
// Operand/result bundle for alu_8; master drives operands, slave returns flags and result.
interface alu_8_if;
  import alu_8_pkg::*;
  logic [3:0]    opcode;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW:0]   res;
  logic          carry;
  logic          zero;

  modport master (output opcode, a, b, input  res, carry, zero);
  modport slave  (input  opcode, a, b, output res, carry, zero);
endinterface

// File: rtl/alu_8_addsub.sv
// Shared adder/subtractor: sub_i inverts b, cin_i completes two's complement or adds one.
module alu_8_addsub
  import alu_8_pkg::*;
(
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic          sub_i,
  input  logic          cin_i,
  output logic [DW-1:0] sum_o,
  output logic          cout_o
);
  logic [DW-1:0] b_eff;

  assign b_eff = sub_i ? ~b_i : b_i;
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{DW{1'b0}}, cin_i};
endmodule

// File: rtl/alu_8.sv
// Registered 8-bit ALU, one-cycle latency. Define ALU_8_MUL_EN to build the
// 8x8 multiplier for opcode 2; otherwise opcode 2 yields a zero result.
module alu_8
  import alu_8_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  alu_8_if.slave bus
);
  op_e           op;
  logic          as_sub, as_cin, as_cout;
  logic [DW-1:0] as_b, as_sum;
  logic [DW:0]   res_d, res_q;
  logic          carry_d, carry_q;
  logic          zero_d, zero_q;
  logic [DW-1:0] a;

  assign op = op_e'(bus.opcode);
  assign a  = bus.a;

`ifdef ALU_8_MUL_EN
  logic [2*DW-1:0] prod;
  assign prod = a * bus.b;
`endif

  // ADD/SUB/INC/CMP share one carry chain; SUB/CMP borrow is the inverted carry-out.
  always_comb begin
    as_sub = 1'b0;
    as_cin = 1'b0;
    as_b   = bus.b;
    case (op)
      OP_SUB, OP_CMP: begin as_sub = 1'b1; as_cin = 1'b1; end
      OP_INC:         begin as_b = '0; as_cin = 1'b1; end
      default: ;
    endcase
  end

  alu_8_addsub u_addsub (
    .a_i   (a),
    .b_i   (as_b),
    .sub_i (as_sub),
    .cin_i (as_cin),
    .sum_o (as_sum),
    .cout_o(as_cout)
  );

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    case (op)
      OP_ADD:  begin carry_d = as_cout;  res_d = {as_cout, as_sum}; end
      OP_SUB:  begin carry_d = ~as_cout; res_d = {~as_cout, as_sum}; end
`ifdef ALU_8_MUL_EN
      OP_MUL:  begin carry_d = |prod[2*DW-1:DW+1]; res_d = prod[DW:0]; end
`endif
      OP_AND:  res_d = {1'b0, a & bus.b};
      OP_OR:   res_d = {1'b0, a | bus.b};
      OP_XOR:  res_d = {1'b0, a ^ bus.b};
      OP_NAND: res_d = {1'b0, ~(a & bus.b)};
      OP_NOR:  res_d = {1'b0, ~(a | bus.b)};
      OP_XNOR: res_d = {1'b0, ~(a ^ bus.b)};
      OP_NOT:  res_d = {1'b0, ~a};
      OP_SHL:  begin carry_d = a[DW-1]; res_d = {1'b0, a[DW-2:0], 1'b0}; end
      OP_SHR:  begin carry_d = a[0];    res_d = {2'b00, a[DW-1:1]}; end
      OP_ROL:  begin carry_d = a[DW-1]; res_d = {1'b0, a[DW-2:0], a[DW-1]}; end
      OP_ROR:  begin carry_d = a[0];    res_d = {1'b0, a[0], a[DW-1:1]}; end
      OP_INC:  begin carry_d = as_cout; res_d = {as_cout, as_sum}; end
      // CMP: a<b is the borrow, equality is a zero difference.
      OP_CMP:  begin carry_d = (as_sum == '0); res_d = {{DW{1'b0}}, ~as_cout}; end
      default: ;
    endcase
    zero_d = (res_d[DW-1:0] == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.res   = res_q;
  assign bus.carry = carry_q;
  assign bus.zero  = zero_q;
endmodule

// File: tb/tb_alu_8.sv
// Scoreboard bench for alu_8: stimulus pushes model results, monitor pops one per clock.
module tb_alu_8;
  logic clk = 1'b0;
  logic rst_n;

  alu_8_if bus ();

  alu_8 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] res;
    logic       c;
    logic       z;
    logic [3:0] op;
    logic       rst;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 0;

  // Reference model written directly from the operation table with integer arithmetic.
  function automatic exp_t model(bit rst, int op, int a, int b);
    exp_t e;
    int r, c, p;
    bit arith;
    r = 0; c = 0; arith = 0;
    e.op = 4'(op);
    e.rst = rst;
    if (!rst) begin
      e.res = 9'd0; e.c = 1'b0; e.z = 1'b1;
      return e;
    end
    case (op)
      0:  begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; arith = 1; end
      1:  begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; arith = 1; end
      2:  begin
`ifdef ALU_8_MUL_EN
            p = a * b; r = p % 512; c = (p >= 512) ? 1 : 0;
`else
            p = 0; r = p; c = 0;
`endif
          end
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      6:  r = 255 - (a & b);
      7:  r = 255 - (a | b);
      8:  r = 255 - (a ^ b);
      9:  r = 255 - a;
      10: begin r = (a * 2) % 256; c = a / 128; end
      11: begin r = a / 2; c = a % 2; end
      12: begin r = (a * 2) % 256 + a / 128; c = a / 128; end
      13: begin r = a / 2 + (a % 2) * 128; c = a % 2; end
      14: begin r = (a + 1) % 256; c = (a == 255) ? 1 : 0; arith = 1; end
      default: begin r = (a < b) ? 1 : 0; c = (a == b) ? 1 : 0; end
    endcase
    if (arith) r = r + c * 256;
    e.res = 9'(r);
    e.c   = (c != 0);
    e.z   = ((r % 256) == 0);
    return e;
  endfunction

  task automatic drive(bit rst, int op, int a, int b);
    @(negedge clk);
    rst_n      = rst;
    bus.opcode = 4'(op);
    bus.a      = 8'(a);
    bus.b      = 8'(b);
    exp_q.push_back(model(rst, op, a, b));
  endtask

  // Monitor: the unit produces a result every edge, so pop one expectation per edge.
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.res !== e.res || bus.carry !== e.c || bus.zero !== e.z) begin
          failures++;
          $display("FAIL op%0h rst_n=%0b: got res=%h c=%b z=%b, want res=%h c=%b z=%b",
                   e.op, e.rst, bus.res, bus.carry, bus.zero, e.res, e.c, e.z);
        end
      end
    end
  end

  initial begin
    int a, b;
    rst_n = 1'b0; bus.opcode = 4'h0; bus.a = 8'h00; bus.b = 8'h00;

    drive(0, 0, 8'h14, 8'h4F);
    drive(0, 0, 8'h14, 8'h4F);
    drive(1, 0, 8'h14, 8'h4F);
    for (int op = 1; op < 16; op++) drive(1, op, 8'h14, 8'h4F);

    drive(1, 0,  8'hFF, 8'h01);
    drive(1, 14, 8'hFF, 8'h01);
    drive(1, 1,  8'h55, 8'h55);
    drive(1, 15, 8'h55, 8'h55);
    drive(1, 10, 8'h81, 8'h00);
    drive(1, 13, 8'h81, 8'h00);
    drive(1, 2,  8'h00, 8'h00);
    drive(1, 2,  8'hFF, 8'hFF);

    // Reset dropped in the middle of a sweep, then resumed.
    for (int op = 0; op < 16; op++) drive((op != 7), op, 8'hA7, 8'h3C);

    for (int i = 0; i < 400; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) != 0) ? 255 : 0;
      if ($urandom_range(0, 7) == 0) b = a;
      drive(($urandom_range(0, 19) != 0), int'($urandom_range(0, 15)), a, b);
    end

    // Let the last expectation drain, bounded to a few cycles.
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
